// File: rtl/bus_sync_pkg.sv
// Shared types and constants for the bus_sync_handshake clock-domain crossing.
// Option macro: BUS_SYNC_OUT_READY_EN (adds the out_ready back-pressure port).
package bus_sync_pkg;

    localparam int STAGES_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } src_state_e;

endpackage

// File: rtl/sync_bit_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
// Used on both the req (to clk_out) and ack (to clk_in) paths.
module sync_bit_chain #(
    parameter int STAGES = 3
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/bus_sync_handshake.sv
// Toggle req/ack handshake moving a WIDTH-bit word from clk_in to clk_out.
// Option macro: BUS_SYNC_OUT_READY_EN (out_valid held until out_ready).
module bus_sync_handshake
    import bus_sync_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clk_in,
    input  logic             arst_in,
    input  logic             clk_out,
    input  logic             arst_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dat_in,
    output logic             in_ovf,
    output logic             out_valid,
`ifdef BUS_SYNC_OUT_READY_EN
    input  logic             out_ready,
`endif
    output logic [WIDTH-1:0] dat_out
);

    generate
        if (STAGES < STAGES_MIN) begin : g_bad_stages
            $error("bus_sync_handshake: STAGES must be at least 2");
        end
    endgenerate

    // ---------------- source domain (clk_in) ----------------
    src_state_e       r_state;
    src_state_e       w_state_nxt;
    logic             w_capture;
    logic             w_ovf_set;
    logic [WIDTH-1:0] r_hold;
    logic             r_req;
    logic             r_ovf;
    logic             w_ack_sync;

    // ---------------- destination domain (clk_out) ----------------
    logic             w_req_sync;
    logic             r_req_seen;
    logic             r_ack;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_dat_out;
    logic             w_new;

    sync_bit_chain #(.STAGES(STAGES)) u_req_sync (
        .i_clk  (clk_out),
        .i_arst (arst_out),
        .i_d    (r_req),
        .o_q    (w_req_sync)
    );

    sync_bit_chain #(.STAGES(STAGES)) u_ack_sync (
        .i_clk  (clk_in),
        .i_arst (arst_in),
        .i_d    (r_ack),
        .o_q    (w_ack_sync)
    );

    // Source FSM state register.
    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Source FSM next state, capture strobe and overflow detection.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ovf_set   = 1'b0;
        in_ready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_ovf_set = in_valid;
                if (w_ack_sync == r_req) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // Hold register, req toggle and sticky overflow flag.
    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            r_hold <= '0;
            r_req  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold <= dat_in;
                r_req  <= ~r_req;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ovf = r_ovf;

    // A req edge not yet acknowledged means r_hold carries a new word.
    assign w_new = (w_req_sync != r_req_seen);

    // Destination: load the held word and return the ack toggle.
    always_ff @(posedge clk_out or posedge arst_out) begin
        if (arst_out) begin
            r_req_seen  <= 1'b0;
            r_ack       <= 1'b0;
            r_out_valid <= 1'b0;
            r_dat_out   <= '0;
        end else begin
`ifdef BUS_SYNC_OUT_READY_EN
            if (r_out_valid) begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_ack       <= ~r_ack;
                end
            end else if (w_new) begin
                r_dat_out   <= r_hold;
                r_out_valid <= 1'b1;
                r_req_seen  <= w_req_sync;
            end
`else
            r_out_valid <= w_new;
            if (w_new) begin
                r_dat_out  <= r_hold;
                r_req_seen <= w_req_sync;
                r_ack      <= ~r_ack;
            end
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign dat_out   = r_dat_out;

endmodule

// File: tb/tb_bus_sync_handshake.sv
// Bench for bus_sync_handshake: queue reference model of accepted words.
// Build with or without BUS_SYNC_OUT_READY_EN.
module tb_bus_sync_handshake;

    logic        clk_in;
    logic        arst_in;
    logic        clk_out;
    logic        arst_out;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dat_in;
    logic        in_ovf;
    logic        out_valid;
    logic [15:0] dat_out;
    logic        mon_take;
`ifdef BUS_SYNC_OUT_READY_EN
    logic        out_ready;
`endif

    int          n_chk;
    int          n_err;
    int          n_dlv;
    logic [15:0] exp_q[$];

    bus_sync_handshake #(
        .WIDTH  (16),
        .STAGES (3)
    ) dut (
        .clk_in    (clk_in),
        .arst_in   (arst_in),
        .clk_out   (clk_out),
        .arst_out  (arst_out),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dat_in    (dat_in),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
`ifdef BUS_SYNC_OUT_READY_EN
        .out_ready (out_ready),
`endif
        .dat_out   (dat_out)
    );

    // Time unit is 100 ps: clk_in 10 ns (100 MHz), clk_out 27 ns (~37 MHz).
    initial begin
        clk_in = 1'b0;
        forever #50 clk_in = ~clk_in;
    end

    initial begin
        clk_out = 1'b0;
        forever #135 clk_out = ~clk_out;
    end

`ifdef BUS_SYNC_OUT_READY_EN
    assign mon_take = out_valid & out_ready;
`else
    assign mon_take = out_valid;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every delivered word must be the oldest accepted, undelivered word.
    always @(negedge clk_out) begin
        if (!arst_out && mon_take) begin
            chk("dlv_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("dlv_order", 32'(dat_out), 32'(exp_q.pop_front()));
            end
            n_dlv++;
        end
    end

    task automatic do_reset();
        arst_in  = 1'b1;
        arst_out = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk_out);
        #1;
        arst_in  = 1'b0;
        arst_out = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!in_ready && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, 32'(in_ready), 1);
    endtask

    // Offer one word following the handshake; the model records it.
    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!in_ready && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 1);
        end else begin
            in_valid = 1'b1;
            dat_in   = w;
            exp_q.push_back(w);
            @(posedge clk_in);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int          k;
        int          base;
        logic [15:0] w;

        n_chk    = 0;
        n_err    = 0;
        n_dlv    = 0;
        in_valid = 1'b0;
        dat_in   = '0;
        arst_in  = 1'b0;
        arst_out = 1'b0;
`ifdef BUS_SYNC_OUT_READY_EN
        out_ready = 1'b1;
`endif
        #3;
        do_reset();

        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dat_out", 32'(dat_out), 0);
        chk("rst_in_ovf", 32'(in_ovf), 0);

        // Single word and latency bound.
        send_word(16'hA5C3);
        chk("busy_after_cap", 32'(in_ready), 0);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_out);
            #1;
            if (out_valid) begin
                k = i;
                break;
            end
        end
        chk("lat_le_5", 32'(k >= 1 && k <= 5), 1);
        chk("single_dat", 32'(dat_out), 32'h0000_A5C3);
        wait_idle("single_idle");
        chk("single_drain", 32'(exp_q.size()), 0);

        // Back-to-back stream of 0..99.
        base = n_dlv;
        for (int i = 0; i < 100; i++) begin
            send_word(16'(i));
        end
        wait_idle("b2b_idle");
        chk("b2b_count", 32'(n_dlv - base), 100);
        chk("b2b_drain", 32'(exp_q.size()), 0);
        chk("b2b_ovf", 32'(in_ovf), 0);

        // Random words with random gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            w = 16'($urandom());
            send_word(w);
        end
        wait_idle("rnd_idle");
        chk("rnd_drain", 32'(exp_q.size()), 0);
        chk("rnd_ovf", 32'(in_ovf), 0);
        chk("rnd_last", 32'(dat_out), 32'(w));

`ifdef BUS_SYNC_OUT_READY_EN
        // Back-pressure: word held while out_ready is low.
        @(posedge clk_out);
        #1;
        out_ready = 1'b0;
        send_word(16'hBEEF);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_out);
            #1;
            if (out_valid) begin
                k = 1;
                break;
            end
        end
        chk("bp_valid_seen", 32'(k), 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_out);
            #1;
            chk("bp_valid_hold", 32'(out_valid), 1);
            chk("bp_dat_hold", 32'(dat_out), 32'h0000_BEEF);
            chk("bp_not_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_drain", 32'(exp_q.size()), 0);
        chk("bp_valid_clr", 32'(out_valid), 0);
`endif

        // Overflow: a second offer while busy is dropped and flagged.
        send_word(16'h0F0F);
        @(negedge clk_in);
        chk("ovf_busy", 32'(in_ready), 0);
        in_valid = 1'b1;
        dat_in   = 16'hDEAD;
        @(negedge clk_in);
        in_valid = 1'b0;
        wait_idle("ovf_idle");
        chk("ovf_drain", 32'(exp_q.size()), 0);
        chk("ovf_dat", 32'(dat_out), 32'h0000_0F0F);
        chk("ovf_set", 32'(in_ovf), 1);
        repeat (30) @(negedge clk_in);
        chk("ovf_sticky", 32'(in_ovf), 1);

        // Reset in the middle of a transfer.
        send_word(16'h5555);
        chk("mid_busy", 32'(in_ready), 0);
        do_reset();
        chk("mid_dat_out", 32'(dat_out), 0);
        chk("mid_out_valid", 32'(out_valid), 0);
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_ovf_clr", 32'(in_ovf), 0);
        base = n_dlv;
        send_word(16'h1234);
        wait_idle("post_idle");
        chk("post_count", 32'(n_dlv - base), 1);
        chk("post_dat", 32'(dat_out), 32'h0000_1234);
        chk("post_ovf", 32'(in_ovf), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_sync_handshake.md
BUS_SYNC_HANDSHAKE -- requirements
Module: bus_sync_handshake

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data bus width in bits, minimum 1.
REQ-002 SHALL have parameter STAGES, default 3: synchronizer flop depth per crossing; values below 2 SHALL cause an elaboration error.
REQ-003 SHALL have input clk_in, 1 bit: source clock.
REQ-004 SHALL have input arst_in, 1 bit: reset, asynchronous, active-high, for the clk_in domain.
REQ-005 SHALL have input clk_out, 1 bit: destination clock, asynchronous to clk_in.
REQ-006 SHALL have input arst_out, 1 bit: asynchronous, active-high reset for the clk_out domain.
REQ-007 SHALL have input in_valid, 1 bit (clk_in): source word offered.
REQ-008 SHALL have output in_ready, 1 bit (clk_in): block can accept a word.
REQ-009 SHALL have input dat_in, WIDTH bits (clk_in): source word.
REQ-010 SHALL have output in_ovf, 1 bit (clk_in): sticky flag, in_valid seen while in_ready=0.
REQ-011 SHALL have output out_valid, 1 bit (clk_out): dat_out holds a new word.
REQ-012 SHALL have output dat_out, WIDTH bits (clk_out): delivered word.
REQ-013 SHALL have input out_ready, 1 bit (clk_out), present only with BUS_SYNC_OUT_READY_EN.

Function
REQ-014 Source FSM SHALL have two states: IDLE (in_ready=1) and BUSY (in_ready=0).
REQ-015 IDLE with in_valid=1 SHALL, on the clk_in edge: capture dat_in into hold register, toggle req, go BUSY.
REQ-016 Hold register SHALL remain stable while BUSY; it is the only data crossing the domains and has no per-bit synchronizer.
REQ-017 req SHALL pass to clk_out through a STAGES-flop chain; last stage SHALL be compared against a registered copy (req_seen).
REQ-018 On mismatch, the destination SHALL, on that clk_out edge: load dat_out from hold register, assert out_valid, update req_seen.
REQ-019 Latency: out_valid SHALL rise within STAGES+2 clk_out edges after the req toggle.
REQ-020 Destination SHALL toggle ack when the word is consumed (see Configuration); ack SHALL return to clk_in through a STAGES-flop chain.
REQ-021 BUSY SHALL return to IDLE on the clk_in edge where synchronized ack equals req; in_ready SHALL rise on that edge.
REQ-022 Words SHALL be delivered in order, exactly once; none lost while handshake followed.
REQ-023 in_valid=1 while BUSY SHALL be ignored (no capture) and SHALL set in_ovf, which holds until arst_in.
REQ-024 dat_out SHALL hold its last value between transfers.

Reset
REQ-025 arst_in SHALL clear hold register, req, ack sync chain, in_ovf, and force IDLE (in_ready=1 after release).
REQ-026 arst_out SHALL clear req sync chain, req_seen, ack, dat_out (0), out_valid (0).
REQ-027 Both resets SHALL be asserted together, overlapping at least STAGES cycles of the slower clock; independent reset mid-transfer is not supported.

Configuration
REQ-028 Macro BUS_SYNC_OUT_READY_EN defined: out_ready port exists; out_valid SHALL hold until the clk_out edge with out_ready=1, when out_valid clears and ack toggles; next word SHALL NOT load while out_valid=1.
REQ-029 Macro undefined: out_valid SHALL be a one-clk_out-cycle pulse; ack SHALL toggle on the same edge dat_out loads.

Structure
REQ-030 Package bus_sync_pkg SHALL hold the source state enum (IDLE, BUSY) and constant STAGES_MIN=2.
REQ-031 One sub-module sync_bit_chain (1-bit, STAGES-deep, async reset to 0) SHALL be instantiated twice: req path and ack path.

Verification
REQ-032 Single word: WIDTH=16, STAGES=3, dat_in=16'hA5C3 with in_valid pulse -> dat_out=16'hA5C3, out_valid within 5 clk_out edges; in_ready high again afterwards.
REQ-033 Back-to-back stream: 100 words 0..99, clk_in 100 MHz, clk_out 37 MHz, in_valid held -> 100 words in order, no duplicates, in_ovf=0.
REQ-034 Overflow: second in_valid while BUSY -> word not delivered, in_ovf=1 until arst_in.
REQ-035 With BUS_SYNC_OUT_READY_EN: out_ready=0 for 50 cycles -> out_valid and dat_out held, in_ready stays 0; out_ready=1 -> completion, in_ready rises.
REQ-036 Reset mid-transfer: both resets asserted while BUSY -> dat_out=0, out_valid=0, in_ready=1 after release; next word 16'h1234 delivered correctly.
REQ-037 STAGES=1 -> elaboration fails.
